sort_result_checker: RTL and testbench

//  Self-checking harness block for CPU program runs (e.g. quicksort). Waits for the core to halt
//  (PC stable), then reads LENGTH words from data memory at BASE_ADDR and checks their ordering.
//  It reports pass/fail, the violation count, the first violating index and an additive checksum.
//  It sits beside Top/Data_Memory and owns a read-only port that is muxed onto the memory while busy.

---
 rtl/sort_result_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_sort_result_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_result_checker.sv
// Sort result checker: waits for the core to halt (stable pc), then reads
// `length` words from data memory starting at `base_addr` and checks their
// ordering. Reports pass/fail, the violation count, the first violating
// index and an additive checksum. Owns a read-only memory port that is only
// driven while the scan is in progress.
module sort_result_checker #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned HALT_CYC  = 8,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              descending,
    input  logic              signed_cmp,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [LEN_W-1:0]  viol_count,
    output logic [LEN_W-1:0]  first_viol,
    output logic [DATA_W-1:0] checksum
);

    // Element stride in bytes; assumed to be a power of two.
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);

    localparam int unsigned HALT_W    = (HALT_CYC > 1) ? $clog2(HALT_CYC) : 1;
    localparam logic [HALT_W-1:0] HALT_LAST = HALT_W'(HALT_CYC - 1);

    // WAIT holds READ_LAT-1 cycles; counter runs 0 .. READ_LAT-2.
    localparam int unsigned WAIT_W    = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
    localparam int unsigned WAIT_LAST = (READ_LAT > 1) ? READ_LAT - 2 : 0;
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(WAIT_LAST);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StReq,
        StWait,
        StCmp,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]    pc_prev_q;
    logic [HALT_W-1:0]    hc_q, hc_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 desc_q, desc_d;
    logic                 sgn_q, sgn_d;
    logic                 aligned_q, aligned_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    prev_q, prev_d;
    logic [DATA_W-1:0]    checksum_q, checksum_d;
    logic [LEN_W-1:0]     viol_q, viol_d;
    logic [LEN_W-1:0]     first_q, first_d;
    logic                 timed_out_q, timed_out_d;

    logic prev_gt, prev_lt, viol_hit;

    // Ordering check of the incoming element against the previous one.
    always_comb begin
        prev_gt = 1'b0;
        prev_lt = 1'b0;
        if (sgn_q) begin
            prev_gt = $signed(prev_q) > $signed(mem_rdata);
            prev_lt = $signed(prev_q) < $signed(mem_rdata);
        end else begin
            prev_gt = prev_q > mem_rdata;
            prev_lt = prev_q < mem_rdata;
        end
        viol_hit = (idx_q != '0) && (desc_q ? prev_lt : prev_gt);
    end

    // Next-state, datapath updates and memory port drive.
    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        wd_d        = wd_q;
        wait_d      = wait_q;
        idx_d       = idx_q;
        len_d       = len_q;
        desc_d      = desc_q;
        sgn_d       = sgn_q;
        aligned_d   = aligned_q;
        addr_d      = addr_q;
        prev_d      = prev_q;
        checksum_d  = checksum_q;
        viol_d      = viol_q;
        first_d     = first_q;
        timed_out_d = timed_out_q;
        mem_read    = 1'b0;
        mem_addr    = mem_addr_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    len_d       = length;
                    desc_d      = descending;
                    sgn_d       = signed_cmp;
                    aligned_d   = (base_addr & ALIGN_MASK) == '0;
                    addr_d      = base_addr;
                    hc_d        = '0;
                    wd_d        = '0;
                    wait_d      = '0;
                    idx_d       = '0;
                    prev_d      = '0;
                    checksum_d  = '0;
                    viol_d      = '0;
                    first_d     = '1;
                    timed_out_d = 1'b0;
                    state_d     = StArm;
                end
            end
            StArm: begin
                wd_d = wd_q + 1'b1;
                hc_d = (pc == pc_prev_q) ? hc_q + 1'b1 : '0;
                // Halt takes priority over a coincident watchdog expiry.
                if (hc_d == HALT_LAST) begin
                    if (!aligned_q || len_q == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end else if (wd_d == {TIMEOUT_W{1'b1}}) begin
                    timed_out_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StReq: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                wait_d   = '0;
                state_d  = (READ_LAT == 1) ? StCmp : StWait;
            end
            StWait: begin
                if (wait_q == WAIT_END) begin
                    state_d = StCmp;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StCmp: begin
                checksum_d = checksum_q + mem_rdata;
                if (viol_hit) begin
                    if (viol_q != {LEN_W{1'b1}}) begin
                        viol_d = viol_q + 1'b1;
                    end
                    if (first_q == {LEN_W{1'b1}}) begin
                        first_d = idx_q;
                    end
                end
                prev_d = mem_rdata;
                idx_d  = idx_q + 1'b1;
                addr_d = addr_q + STRIDE;
                state_d = (idx_d == len_q) ? StDone : StReq;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_prev_q   <= '0;
            hc_q        <= '0;
            wd_q        <= '0;
            wait_q      <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            desc_q      <= 1'b0;
            sgn_q       <= 1'b0;
            aligned_q   <= 1'b0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            prev_q      <= '0;
            checksum_q  <= '0;
            viol_q      <= '0;
            first_q     <= '1;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_prev_q   <= pc;
            hc_q        <= hc_d;
            wd_q        <= wd_d;
            wait_q      <= wait_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            desc_q      <= desc_d;
            sgn_q       <= sgn_d;
            aligned_q   <= aligned_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr;
            prev_q      <= prev_d;
            checksum_q  <= checksum_d;
            viol_q      <= viol_d;
            first_q     <= first_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Status outputs derived from state and result registers.
    always_comb begin
        busy       = (state_q == StArm) || (state_q == StReq) ||
                     (state_q == StWait) || (state_q == StCmp);
        done       = (state_q == StDone);
        pass       = done && (viol_q == '0) && !timed_out_q && aligned_q;
        timed_out  = timed_out_q;
        viol_count = viol_q;
        first_viol = first_q;
        checksum   = checksum_q;
    end

endmodule

// File: tb/tb_sort_result_checker.sv
// Directed bench for sort_result_checker: one instance with single-cycle
// memory latency, one with three-cycle latency, both with a 4-bit watchdog.
module tb_sort_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start3;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic        descending, signed_cmp;
    logic [31:0] pc = 32'h0000_0100;
    logic        pc_toggle;
    logic        log_clr;

    logic        mem_read1, busy1, done1, pass1, timed_out1;
    logic [31:0] mem_addr1, rdata1, checksum1;
    logic [15:0] viol1, first1;

    logic        mem_read3, busy3, done3, pass3, timed_out3;
    logic [31:0] mem_addr3, rdata3, checksum3;
    logic [15:0] viol3, first3;

    logic [31:0] mem [0:255];
    logic [31:0] p3 [0:2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int rd_n = 0;
    int rd3_n = 0;
    logic [31:0] rd_addr [0:7];
    int rd3_cyc [0:7];

    always #5 clk = ~clk;

    sort_result_checker #(.READ_LAT(1), .TIMEOUT_W(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .base_addr  (base_addr),
        .length     (length),
        .descending (descending),
        .signed_cmp (signed_cmp),
        .pc         (pc),
        .mem_read   (mem_read1),
        .mem_addr   (mem_addr1),
        .mem_rdata  (rdata1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .timed_out  (timed_out1),
        .viol_count (viol1),
        .first_viol (first1),
        .checksum   (checksum1)
    );

    sort_result_checker #(.READ_LAT(3), .TIMEOUT_W(4)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start3),
        .base_addr  (base_addr),
        .length     (length),
        .descending (descending),
        .signed_cmp (signed_cmp),
        .pc         (pc),
        .mem_read   (mem_read3),
        .mem_addr   (mem_addr3),
        .mem_rdata  (rdata3),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
        .timed_out  (timed_out3),
        .viol_count (viol3),
        .first_viol (first3),
        .checksum   (checksum3)
    );

    // Memory models: data valid only in the cycle READ_LAT after the strobe.
    always @(posedge clk) begin
        rdata1 <= mem_read1 ? mem[mem_addr1[9:2]] : 32'hDEAD_BEEF;
        p3[0]  <= mem_read3 ? mem[mem_addr3[9:2]] : 32'hDEAD_BEEF;
        p3[1]  <= p3[0];
        p3[2]  <= p3[1];
    end
    assign rdata3 = p3[2];

    // Program counter: static unless toggling is requested.
    always @(posedge clk) begin
        if (pc_toggle) pc <= pc ^ 32'h4;
    end

    // Read log: addresses for the fast instance, issue cycles for the slow one.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (log_clr) begin
            rd_n  <= 0;
            rd3_n <= 0;
        end else begin
            if (mem_read1) begin
                if (rd_n < 8) rd_addr[rd_n] <= mem_addr1;
                rd_n <= rd_n + 1;
            end
            if (mem_read3) begin
                if (rd3_n < 8) rd3_cyc[rd3_n] <= cyc;
                rd3_n <= rd3_n + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_scan(input bit use3, input logic [31:0] base, input logic [15:0] len,
                            input logic desc, input logic sgn);
        int waited;
        @(negedge clk);
        base_addr  = base;
        length     = len;
        descending = desc;
        signed_cmp = sgn;
        log_clr    = 1'b1;
        if (use3) start3 = 1'b1;
        else      start1 = 1'b1;
        @(negedge clk);
        start1  = 1'b0;
        start3  = 1'b0;
        log_clr = 1'b0;
        waited  = 0;
        while (!(use3 ? done3 : done1) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check_eq("done_reached", 64'(use3 ? done3 : done1), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int waited;
        rst = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        base_addr = 32'd0;
        length = 16'd0;
        descending = 1'b0;
        signed_cmp = 1'b0;
        pc_toggle = 1'b0;
        log_clr = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        // Reset values
        #15;
        check_eq("rst_done", 64'(done1), 64'd0);
        check_eq("rst_busy", 64'(busy1), 64'd0);
        check_eq("rst_pass", 64'(pass1), 64'd0);
        check_eq("rst_first", 64'(first1), 64'hFFFF);
        check_eq("rst_sum", 64'(checksum1), 64'd0);
        check_eq("rst_memrd", 64'(mem_read1), 64'd0);
        #5 rst = 1'b0;

        // 1: ascending unsigned {1,2,3} at 4336 (word index 60)
        mem[60] = 32'd1; mem[61] = 32'd2; mem[62] = 32'd3;
        run_scan(0, 32'd4336, 16'd3, 1'b0, 1'b0);
        check_eq("t1_nreads", 64'(rd_n), 64'd3);
        check_eq("t1_addr0", 64'(rd_addr[0]), 64'd4336);
        check_eq("t1_addr1", 64'(rd_addr[1]), 64'd4340);
        check_eq("t1_addr2", 64'(rd_addr[2]), 64'd4344);
        check_eq("t1_pass", 64'(pass1), 64'd1);
        check_eq("t1_viol", 64'(viol1), 64'd0);
        check_eq("t1_first", 64'(first1), 64'hFFFF);
        check_eq("t1_sum", 64'(checksum1), 64'd6);
        check_eq("t1_busy", 64'(busy1), 64'd0);

        // 2: {5,-1,3} signed then unsigned ascending
        mem[60] = 32'd5; mem[61] = 32'hFFFF_FFFF; mem[62] = 32'd3;
        run_scan(0, 32'd4336, 16'd3, 1'b0, 1'b1);
        check_eq("t2s_viol", 64'(viol1), 64'd1);
        check_eq("t2s_first", 64'(first1), 64'd1);
        check_eq("t2s_pass", 64'(pass1), 64'd0);
        check_eq("t2s_sum", 64'(checksum1), 64'd7);
        run_scan(0, 32'd4336, 16'd3, 1'b0, 1'b0);
        check_eq("t2u_viol", 64'(viol1), 64'd1);
        check_eq("t2u_first", 64'(first1), 64'd2);

        // 3: {9,9,4,4} descending, then ascending
        mem[60] = 32'd9; mem[61] = 32'd9; mem[62] = 32'd4; mem[63] = 32'd4;
        run_scan(0, 32'd4336, 16'd4, 1'b1, 1'b0);
        check_eq("t3d_pass", 64'(pass1), 64'd1);
        check_eq("t3d_sum", 64'(checksum1), 64'd26);
        run_scan(0, 32'd4336, 16'd4, 1'b0, 1'b0);
        check_eq("t3a_viol", 64'(viol1), 64'd1);
        check_eq("t3a_first", 64'(first1), 64'd2);
        check_eq("t3a_pass", 64'(pass1), 64'd0);

        // 4: pc never settles; watchdog fires after 15 armed cycles
        pc_toggle = 1'b1;
        @(negedge clk);
        base_addr = 32'd4336;
        length = 16'd3;
        start1 = 1'b1;
        log_clr = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        log_clr = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("t4_not_early", 64'(done1), 64'd0);
        check_eq("t4_busy", 64'(busy1), 64'd1);
        @(negedge clk);
        check_eq("t4_done", 64'(done1), 64'd1);
        check_eq("t4_timed_out", 64'(timed_out1), 64'd1);
        check_eq("t4_pass", 64'(pass1), 64'd0);
        check_eq("t4_nreads", 64'(rd_n), 64'd0);
        pc_toggle = 1'b0;

        // 5: empty list, misaligned base, and read spacing at READ_LAT=3
        run_scan(0, 32'd4336, 16'd0, 1'b0, 1'b0);
        check_eq("t5_len0_pass", 64'(pass1), 64'd1);
        check_eq("t5_len0_reads", 64'(rd_n), 64'd0);
        check_eq("t5_len0_sum", 64'(checksum1), 64'd0);
        run_scan(0, 32'd4338, 16'd3, 1'b0, 1'b0);
        check_eq("t5_mis_pass", 64'(pass1), 64'd0);
        check_eq("t5_mis_reads", 64'(rd_n), 64'd0);
        check_eq("t5_mis_to", 64'(timed_out1), 64'd0);
        run_scan(1, 32'd4336, 16'd2, 1'b0, 1'b0);
        check_eq("t5_lat3_reads", 64'(rd3_n), 64'd2);
        check_eq("t5_lat3_gap", 64'(rd3_cyc[1] - rd3_cyc[0]), 64'd4);
        check_eq("t5_lat3_sum", 64'(checksum3), 64'd18);
        check_eq("t5_lat3_pass", 64'(pass3), 64'd1);

        // 6: reset while waiting on the second read, then a clean rescan
        mem[60] = 32'd1; mem[61] = 32'd2; mem[62] = 32'd3;
        @(negedge clk);
        base_addr = 32'd4336;
        length = 16'd3;
        descending = 1'b0;
        signed_cmp = 1'b0;
        start3 = 1'b1;
        log_clr = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        log_clr = 1'b0;
        waited = 0;
        while (rd3_n < 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_eq("t6_in_wait", 64'(rd3_n), 64'd2);
        check_eq("t6_pre_sum", 64'(checksum3), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_busy", 64'(busy3), 64'd0);
        check_eq("t6_rst_sum", 64'(checksum3), 64'd0);
        check_eq("t6_rst_first", 64'(first3), 64'hFFFF);
        check_eq("t6_rst_addr", 64'(mem_addr3), 64'd0);
        check_eq("t6_rst_done1", 64'(done1), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_scan(1, 32'd4336, 16'd3, 1'b0, 1'b0);
        check_eq("t6_re_pass", 64'(pass3), 64'd1);
        check_eq("t6_re_sum", 64'(checksum3), 64'd6);
        check_eq("t6_re_reads", 64'(rd3_n), 64'd3);
        check_eq("t6_re_viol", 64'(viol3), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
